// File: rtl/dma_ring_buffer_pkg.sv
// Shared constants and helpers for dma_ring_buffer: read latency, derived widths, occ field placement.
// Optional feature macro used by the block: DMA_RING_BUFFER_ERR_EN.
package dma_pkg;

    localparam int DMA_RD_LAT = 2;

    function automatic int dma_chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int dma_cntw(input int depth, input int nch);
        return $clog2(depth / nch) + 1;
    endfunction

    // Bit offset of channel ch's counter inside the packed occ bus (channel 0 in LSBs).
    function automatic int dma_occ_lsb(input int ch, input int cntw);
        return ch * cntw;
    endfunction

endpackage

// File: rtl/dma_ring_buffer_ctrl.sv
// Per-channel pointer/count/flag tracker; acceptance is same-cycle from registered full/empty.
// Error flags (overflow/underflow, sticky) exist only when DMA_RING_BUFFER_ERR_EN is defined.
module dma_ring_ctrl #(
    parameter int CH_DEPTH = 2048,
    parameter int PTRW     = 11,
    parameter int CNTW     = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_req_i,
    input  logic            rd_req_i,
`ifdef DMA_RING_BUFFER_ERR_EN
    input  logic            err_clr_i,
    output logic            err_ovf_o,
    output logic            err_udf_o,
`endif
    output logic            wr_acc_o,
    output logic            rd_acc_o,
    output logic [PTRW-1:0] wptr_o,
    output logic [PTRW-1:0] rptr_o,
    output logic [CNTW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            full_q, full_d, empty_q, empty_d;

    assign wr_acc_o = wr_req_i && !full_q;
    assign rd_acc_o = rd_req_i && !empty_q;

    always_comb begin
        wptr_d = wptr_q + PTRW'(wr_acc_o);
        rptr_d = rptr_q + PTRW'(rd_acc_o);
        cnt_d  = cnt_q;
        if (wr_acc_o && !rd_acc_o) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (rd_acc_o && !wr_acc_o) begin
            cnt_d = cnt_q - CNTW'(1);
        end
        full_d  = (cnt_d == CNTW'(CH_DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign cnt_o   = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

`ifdef DMA_RING_BUFFER_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new error event outranks a clear in the same cycle.
    always_comb begin
        ovf_d = err_clr_i ? 1'b0 : ovf_q;
        udf_d = err_clr_i ? 1'b0 : udf_q;
        if (wr_req_i && full_q)  ovf_d = 1'b1;
        if (rd_req_i && empty_q) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_ovf_o = ovf_q;
    assign err_udf_o = udf_q;
`endif

endmodule

// File: rtl/dma_ring_buffer.sv
// Multi-channel circular line buffer over one dual-port RAM; pops return data 2 cycles after rack.
// Optional error flags under DMA_RING_BUFFER_ERR_EN; no output backpressure, writes/pops gated by full/empty.
module dma_ring_buffer
    import dma_pkg::*;
#(
    parameter  int WIDTH    = 512,
    parameter  int DEPTH    = 8192,
    parameter  int NUM_CH   = 4,
    localparam int CH_DEPTH = DEPTH / NUM_CH,
    localparam int ADDRW    = $clog2(DEPTH),
    localparam int CHW      = dma_chw(NUM_CH),
    localparam int CNTW     = dma_cntw(DEPTH, NUM_CH),
    localparam int BYENW    = WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [CHW-1:0]         wch,
    input  logic [BYENW-1:0]       wben,
    input  logic [WIDTH-1:0]       wdata,
    output logic [NUM_CH-1:0]      wfull,
    input  logic                   ren,
    input  logic [CHW-1:0]         rch,
    output logic                   rack,
    output logic                   rvalid,
    output logic [CHW-1:0]         rdata_ch,
    output logic [WIDTH-1:0]       rdata,
    output logic [NUM_CH-1:0]      rempty,
`ifdef DMA_RING_BUFFER_ERR_EN
    output logic [NUM_CH-1:0]      err_ovf,
    output logic [NUM_CH-1:0]      err_udf,
    input  logic                   err_clr,
`endif
    output logic [NUM_CH*CNTW-1:0] occ
);

    localparam int PTRW = $clog2(CH_DEPTH);

    logic [NUM_CH-1:0] wr_req, rd_req, wr_acc, rd_acc;
    logic [PTRW-1:0]   wptr [NUM_CH];
    logic [PTRW-1:0]   rptr [NUM_CH];
    logic [CNTW-1:0]   cnt  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_req[g] = wen && (wch == CHW'(g));
        assign rd_req[g] = ren && (rch == CHW'(g));

        dma_ring_ctrl #(
            .CH_DEPTH (CH_DEPTH),
            .PTRW     (PTRW),
            .CNTW     (CNTW)
        ) u_ctrl (
            .clk       (clk),
            .rst       (rst),
            .wr_req_i  (wr_req[g]),
            .rd_req_i  (rd_req[g]),
`ifdef DMA_RING_BUFFER_ERR_EN
            .err_clr_i (err_clr),
            .err_ovf_o (err_ovf[g]),
            .err_udf_o (err_udf[g]),
`endif
            .wr_acc_o  (wr_acc[g]),
            .rd_acc_o  (rd_acc[g]),
            .wptr_o    (wptr[g]),
            .rptr_o    (rptr[g]),
            .cnt_o     (cnt[g]),
            .full_o    (wfull[g]),
            .empty_o   (rempty[g])
        );

        assign occ[dma_occ_lsb(g, CNTW) +: CNTW] = cnt[g];
    end

    logic             wr_any, rd_any;
    logic [ADDRW-1:0] waddr, raddr;

    assign wr_any = |wr_acc;
    assign rd_any = |rd_acc;
    assign rack   = rd_any;
    // Channel index forms the upper address bits, so each channel owns a contiguous region.
    assign waddr  = ADDRW'({wch, wptr[wch]});
    assign raddr  = ADDRW'({rch, rptr[rch]});

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (wr_any) begin
            for (int b = 0; b < BYENW; b++) begin
                if (wben[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_any) ram_q <= mem[raddr];
    end

    logic             v1_q, rvalid_q;
    logic [CHW-1:0]   ch1_q, rdata_ch_q;
    logic [WIDTH-1:0] rdata_q;

    // Valid bits are reset, so reads in flight across a reset never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            ch1_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_ch_q <= '0;
            rdata_q    <= '0;
        end else begin
            v1_q     <= rd_any;
            rvalid_q <= v1_q;
            if (rd_any) ch1_q <= rch;
            if (v1_q) begin
                rdata_q    <= ram_q;
                rdata_ch_q <= ch1_q;
            end
        end
    end

    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rdata_ch = rdata_ch_q;

endmodule

// File: tb/tb_dma_ring_buffer.sv
// Self-checking bench for dma_ring_buffer with default parameters; scoreboard queue for popped lines.
module tb_dma_ring_buffer;

    localparam int W   = 512;
    localparam int NCH = 4;
    localparam int CHD = 2048;
    localparam int CW  = 12;

    logic            clk, rst, wen, ren, rack, rvalid;
    logic [1:0]      wch, rch, rdata_ch;
    logic [63:0]     wben;
    logic [W-1:0]    wdata, rdata;
    logic [NCH-1:0]  wfull, rempty;
    logic [NCH*CW-1:0] occ;
`ifdef DMA_RING_BUFFER_ERR_EN
    logic [NCH-1:0]  err_ovf, err_udf;
    logic            err_clr;
`endif

    dma_ring_buffer #(.WIDTH(512), .DEPTH(8192), .NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wch(wch), .wben(wben), .wdata(wdata),
        .wfull(wfull), .ren(ren), .rch(rch), .rack(rack), .rvalid(rvalid),
        .rdata_ch(rdata_ch), .rdata(rdata), .rempty(rempty),
`ifdef DMA_RING_BUFFER_ERR_EN
        .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr),
`endif
        .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
    endtask

    typedef struct {
        int           due;
        int           ch;
        logic [W-1:0] d;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] mem_m [int];
    int cnt_m [NCH];
    int wptr_m [NCH];
    int rptr_m [NCH];
    bit ovf_m [NCH];
    bit udf_m [NCH];

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", W'(rvalid), W'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_latency", W'(cyc_cnt), W'(e.due));
                check("rdata", rdata, e.d);
                check("rdata_ch", W'(rdata_ch), W'(e.ch));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            check("rvalid_missing", W'(rvalid), W'(1));
            void'(sb.pop_front());
        end
    end

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            cnt_m[c] = 0; wptr_m[c] = 0; rptr_m[c] = 0; ovf_m[c] = 0; udf_m[c] = 0;
        end
    endtask

    // One clock cycle of stimulus: called just after a falling edge, returns after the next one.
    task automatic step(input bit we, input int wc, input logic [63:0] be, input logic [W-1:0] wd,
                        input bit re, input int rc);
        bit exp_rack, exp_wacc;
        int addr;
        logic [W-1:0] old_v, new_v;
        wen = we; wch = 2'(wc); wben = be; wdata = wd;
        ren = re; rch = 2'(rc);
        #1;
        exp_rack = re && (cnt_m[rc] != 0);
        exp_wacc = we && (cnt_m[wc] != CHD);
        if (re) check("rack", W'(rack), W'(exp_rack));
        if (re && !exp_rack) udf_m[rc] = 1;
        if (we && !exp_wacc) ovf_m[wc] = 1;
        if (exp_rack) begin
            addr = rc * CHD + rptr_m[rc];
            sb.push_back('{due: cyc_cnt + 2, ch: rc, d: mem_m[addr]});
            rptr_m[rc] = (rptr_m[rc] + 1) % CHD;
            cnt_m[rc]--;
        end
        if (exp_wacc) begin
            addr  = wc * CHD + wptr_m[wc];
            old_v = mem_m.exists(addr) ? mem_m[addr] : '0;
            for (int b = 0; b < 64; b++)
                new_v[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : old_v[b*8 +: 8];
            mem_m[addr] = new_v;
            wptr_m[wc] = (wptr_m[wc] + 1) % CHD;
            cnt_m[wc]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0);
    endtask

    task automatic state_check(input int c);
        check($sformatf("occ%0d", c), W'(occ[c*CW +: CW]), W'(cnt_m[c]));
        check($sformatf("wfull%0d", c), W'(wfull[c]), W'(cnt_m[c] == CHD));
        check($sformatf("rempty%0d", c), W'(rempty[c]), W'(cnt_m[c] == 0));
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 0; ren = 0; wch = 0; rch = 0; wben = '0; wdata = '0;
        #1;
        sb.delete();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_rvalid", W'(rvalid), W'(0));
        check("rst_rack", W'(rack), W'(0));
        check("rst_rdata", rdata, W'(0));
        check("rst_rdata_ch", W'(rdata_ch), W'(0));
        check("rst_rempty", W'(rempty), W'(4'hF));
        check("rst_wfull", W'(wfull), W'(0));
        check("rst_occ", W'(occ), W'(0));
`ifdef DMA_RING_BUFFER_ERR_EN
        check("rst_err_ovf", W'(err_ovf), W'(0));
        check("rst_err_udf", W'(err_udf), W'(0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    localparam logic [63:0] ALL = {64{1'b1}};

    initial begin
`ifdef DMA_RING_BUFFER_ERR_EN
        err_clr = 1'b0;
`endif
        rst = 1'b1; wen = 0; ren = 0; wch = 0; rch = 0; wben = '0; wdata = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Basic FIFO on ch2.
        step(1, 2, ALL, W'(8'hA0), 0, 0);
        step(1, 2, ALL, W'(8'hA1), 0, 0);
        step(1, 2, ALL, W'(8'hA2), 0, 0);
        check("basic_occ2_3", W'(occ[2*CW +: CW]), W'(3));
        step(0, 0, '0, '0, 1, 2);
        step(0, 0, '0, '0, 1, 2);
        step(0, 0, '0, '0, 1, 2);
        idle(3);
        check("basic_occ2_0", W'(occ[2*CW +: CW]), W'(0));
        check("basic_rempty2", W'(rempty[2]), W'(1));

        // Byte merge: slot 0 of ch0 written all-ones, channel wrapped, partial rewrite of slot 0.
        step(1, 0, ALL, {W{1'b1}}, 0, 0);
        for (int i = 1; i < CHD; i++) step(1, 0, ALL, W'(64'hC000 + i), 1, 0);
        state_check(0);
        step(1, 0, 64'h1, '0, 0, 0);
        check("merge_model", mem_m[0], {{(W-8){1'b1}}, 8'h00});
        step(0, 0, '0, '0, 1, 0);
        step(0, 0, '0, '0, 1, 0);
        idle(3);
        state_check(0);

        // Fill ch1 past capacity, then drain it.
        for (int i = 0; i <= CHD; i++) step(1, 1, ALL, W'(64'hB0000 + i), 0, 0);
        check("full_wfull1", W'(wfull[1]), W'(1));
        check("full_occ1", W'(occ[1*CW +: CW]), W'(CHD));
`ifdef DMA_RING_BUFFER_ERR_EN
        check("err_ovf1", W'(err_ovf[1]), W'(1));
`endif
        for (int i = 0; i < CHD; i++) step(0, 0, '0, '0, 1, 1);
        idle(3);
        check("wrap_rempty1", W'(rempty[1]), W'(1));
        check("wrap_wfull1", W'(wfull[1]), W'(0));
        state_check(1);

        // Steady write+pop on ch3 holding 5 lines.
        for (int i = 0; i < 5; i++) step(1, 3, ALL, W'(64'hD000 + i), 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(1, 3, ALL, W'(64'hE000 + i), 1, 3);
            if (i % 25 == 24) check("simul_occ3", W'(occ[3*CW +: CW]), W'(5));
        end
        for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 1, 3);
        idle(3);
        state_check(3);

        // Empty race on ch0.
        step(1, 0, ALL, W'(64'hF00D), 1, 0);
        check("race_rack_model", W'(cnt_m[0]), W'(1));
        step(0, 0, '0, '0, 1, 0);
        idle(3);
`ifdef DMA_RING_BUFFER_ERR_EN
        check("err_udf0", W'(err_udf[0]), W'(1));
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_clr_udf", W'(err_udf), W'(0));
        check("err_clr_ovf", W'(err_ovf), W'(0));
`endif
        state_check(0);

        // Reset one cycle after an accepted pop: the read must vanish.
        step(1, 2, ALL, W'(64'h5A5A), 0, 0);
        step(0, 0, '0, '0, 1, 2);
        do_reset();
        idle(4);
        check("post_rst_occ", W'(occ), W'(0));
        check("post_rst_rempty", W'(rempty), W'(4'hF));

        idle(2);
        check("sb_drained", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
